// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - credit-based instruction fetch with PC-tagged buffer and redirect squash
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] fetch_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   addr_q   [BUF_DEPTH];
  logic [31:0]   buf_pc   [BUF_DEPTH];
  logic [31:0]   buf_data [BUF_DEPTH];
  logic [PW-1:0] aq_wr, aq_rd;
  logic [PW-1:0] bq_wr, bq_rd;
  logic [CW-1:0] occupancy, outstanding, discard;
  logic [CW:0]   credit_used;
  logic          req_fire, resp_fire, drop, push, pop;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // Entries already buffered plus requests still in flight may never exceed the buffer size.
  assign credit_used    = {1'b0, occupancy} + {1'b0, outstanding};
  assign imem_req_valid = !reset && !redirect_valid && (credit_used < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding are protocol violations and are ignored.
  assign resp_fire = imem_resp_valid && (outstanding != '0);
  assign drop      = resp_fire && ((discard != '0) || redirect_valid);
  assign push      = resp_fire && !drop;

  assign inst_valid = (occupancy != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = inst_valid ? buf_data[bq_rd] : 32'h0;
  assign inst_pc    = inst_valid ? buf_pc[bq_rd]   : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      aq_wr       <= '0;
      aq_rd       <= '0;
      bq_wr       <= '0;
      bq_rd       <= '0;
      occupancy   <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      if (req_fire) begin
        addr_q[aq_wr] <= fetch_pc;
        aq_wr         <= aq_wr + 1'b1;
        fetch_pc      <= fetch_pc + 32'd4;
      end
      if (resp_fire) begin
        aq_rd <= aq_rd + 1'b1;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_fire);

      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old stream.
        fetch_pc  <= {redirect_pc[31:2], 2'b00};
        discard   <= outstanding - CW'(resp_fire);
        bq_wr     <= '0;
        bq_rd     <= '0;
        occupancy <= '0;
      end else begin
        if (drop) begin
          discard <= discard - 1'b1;
        end
        if (push) begin
          buf_pc[bq_wr]   <= addr_q[aq_rd];
          buf_data[bq_wr] <= imem_resp_data;
          bq_wr           <= bq_wr + 1'b1;
        end
        if (pop) begin
          bq_rd <= bq_rd + 1'b1;
        end
        occupancy <= occupancy + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched   <= 32'h0;
      perf_discarded <= 32'h0;
    end else begin
      if (pop) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (drop) begin
        perf_discarded <= perf_discarded + 32'd1;
      end
    end
  end
`endif

endmodule
